// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl
//   Time-multiplexed switch debouncer. A prescaler produces a sample tick
//   every TICK_DIV clocks. On each tick the controller visits the N_CH
//   synchronised switch inputs in order, one per clock. For each input it
//   updates a shared-style per-channel stability counter. When an input has
//   differed from its debounced level for STABLE_CNT consecutive scans, the
//   level flips. Each level change is offered as an event through a
//   one-entry valid/ready holding register.
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   sw_in        raw switch inputs (asynchronous to clk)
//   sw_level     debounced switch levels
//   evt_valid    event pending in the holding register
//   evt_ready    consumer accepts the event when evt_valid && evt_ready
//   evt_ch       channel index of the pending event
//   evt_press    1 = level rose (press), 0 = level fell (release)
//   overflow     sticky flag: an event was dropped because the holder was full
//   clr_overflow synchronous clear of overflow (a same-cycle set wins)
module debounce_scan_ctrl #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned STABLE_CNT = 10,
  parameter int unsigned CW         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         sw_in,
  output logic [N_CH-1:0]         sw_level,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_press,
  output logic                    overflow,
  input  logic                    clr_overflow
);

  localparam int unsigned IW = $clog2(N_CH);
  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] level_q, level_d;
  logic            evt_valid_q, evt_valid_d;
  logic [IW-1:0]   evt_ch_q, evt_ch_d;
  logic            evt_press_q, evt_press_d;
  logic            overflow_q, overflow_d;

  logic            tick;
  logic            new_evt;
  logic            new_press;
  logic            accept;
  logic [CW:0]     cnt_inc;

  always_comb begin
    sync1_d   = sw_in;
    sync2_d   = sync1_q;

    tick      = (presc_q == PW'(TICK_DIV - 1));
    presc_d   = tick ? '0 : presc_q + 1'b1;

    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    new_evt   = 1'b0;
    new_press = 1'b0;
    cnt_inc   = '0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        // One extra bit so the +1 compare cannot wrap for any STABLE_CNT.
        cnt_inc = {1'b0, cnt_q[idx_q]} + 1'b1;
        if (sync2_q[idx_q] == level_q[idx_q]) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_inc == (CW+1)'(STABLE_CNT)) begin
          level_d[idx_q] = ~level_q[idx_q];
          cnt_d[idx_q]   = '0;
          new_evt        = 1'b1;
          new_press      = ~level_q[idx_q];
        end else begin
          cnt_d[idx_q] = cnt_inc[CW-1:0];
        end
        if (idx_q == IW'(N_CH - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a slot freed by this cycle's handshake can take the
  // new event on the same edge, so back-to-back events never overflow.
  always_comb begin
    accept      = evt_valid_q & evt_ready;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_press_d = evt_press_q;
    overflow_d  = overflow_q;

    if (clr_overflow) begin
      overflow_d = 1'b0;
    end

    if (new_evt) begin
      if (!evt_valid_q || accept) begin
        evt_valid_d = 1'b1;
        evt_ch_d    = idx_q;
        evt_press_d = new_press;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (accept) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_press_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_press_q <= evt_press_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sw_level  = level_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_press = evt_press_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl
//   Directed bench for debounce_scan_ctrl with N_CH=4, TICK_DIV=16,
//   STABLE_CNT=3. The cycle counter cyc counts rising edges since the last
//   reset release. Scan n (n>=1) processes channel k at edge 16*n+1+k.
module tb_debounce_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] sw_in;
  logic [3:0] sw_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_press;
  logic       overflow;
  logic       clr_overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned evt_cnt  = 0;
  logic [1:0]  last_ch  = '0;
  logic        last_press = 1'b0;

  debounce_scan_ctrl #(
    .N_CH      (4),
    .TICK_DIV  (16),
    .STABLE_CNT(3),
    .CW        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_in       (sw_in),
    .sw_level    (sw_level),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ch      (evt_ch),
    .evt_press   (evt_press),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake logger: inputs only change just after a rising edge, so a
  // valid&&ready seen on the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (reset && evt_valid && evt_ready) begin
      evt_cnt    <= evt_cnt + 1;
      last_ch    <= evt_ch;
      last_press <= evt_press;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int unsigned target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sw_in = '0;
    evt_ready = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  logic [5:0] pat;

  initial begin
    reset = 1'b0;
    sw_in = '0;
    evt_ready = 1'b0;
    clr_overflow = 1'b0;

    // 1: outputs held at zero in reset while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      sw_in = ~sw_in;
      check("rst_level", {28'd0, sw_level}, 32'h0);
      check("rst_valid", {31'd0, evt_valid}, 32'h0);
      check("rst_ovf",   {31'd0, overflow}, 32'h0);
    end
    sw_in = '0;
    evt_ready = 1'b1;
    reset = 1'b1;
    cyc = 0;
    run_to(40);
    check("idle_no_evt", evt_cnt, 0);
    check("idle_level",  {28'd0, sw_level}, 32'h0);

    // 2: ch2 press qualifies on the third scan after sync (edge 83)
    sw_in = 4'b0100;
    run_to(82);
    check("t2_pre_level", {28'd0, sw_level}, 32'h0);
    step();
    check("t2_level", {28'd0, sw_level}, 32'h4);
    check("t2_valid", {31'd0, evt_valid}, 32'h1);
    check("t2_ch",    {30'd0, evt_ch}, 32'h2);
    check("t2_press", {31'd0, evt_press}, 32'h1);
    step();
    check("t2_valid_drop", {31'd0, evt_valid}, 32'h0);
    check("t2_evt_cnt", evt_cnt, 1);
    check("t2_last_ch", {30'd0, last_ch}, 32'h2);

    // 3: bounce on ch1 restarts qualification; flip on 6th scan (edge 178)
    pat = 6'b111011;   // bit k = value for scan 6+k: 1,1,0,1,1,1
    for (int k = 0; k < 6; k++) begin
      run_to(88 + 16 * k);
      sw_in = {2'b01, pat[k], 1'b0};
    end
    run_to(177);
    check("t3_pre_level", {28'd0, sw_level}, 32'h4);
    check("t3_pre_cnt", evt_cnt, 1);
    step();
    check("t3_level", {28'd0, sw_level}, 32'h6);
    check("t3_valid", {31'd0, evt_valid}, 32'h1);
    check("t3_ch",    {30'd0, evt_ch}, 32'h1);
    check("t3_press", {31'd0, evt_press}, 32'h1);
    run_to(185);
    check("t3_evt_cnt", evt_cnt, 2);
    check("t3_last_press", {31'd0, last_press}, 32'h1);

    // 4: two events with no consumer -> second dropped, overflow set
    do_reset();
    run_to(8);
    sw_in = 4'b1001;
    run_to(48);
    check("t4_pre_level", {28'd0, sw_level}, 32'h0);
    check("t4_pre_valid", {31'd0, evt_valid}, 32'h0);
    step();
    check("t4_level0", {28'd0, sw_level}, 32'h1);
    check("t4_valid0", {31'd0, evt_valid}, 32'h1);
    check("t4_ch0",    {30'd0, evt_ch}, 32'h0);
    check("t4_ovf0",   {31'd0, overflow}, 32'h0);
    run_to(51);
    clr_overflow = 1'b1;   // same edge as the drop: set must win
    step();
    check("t4_level3", {28'd0, sw_level}, 32'h9);
    check("t4_hold_ch", {30'd0, evt_ch}, 32'h0);
    check("t4_hold_press", {31'd0, evt_press}, 32'h1);
    check("t4_ovf_set_wins", {31'd0, overflow}, 32'h1);
    step();
    check("t4_ovf_clr", {31'd0, overflow}, 32'h0);
    check("t4_still_valid", {31'd0, evt_valid}, 32'h1);
    clr_overflow = 1'b0;
    evt_ready = 1'b1;
    step();
    check("t4_drained", {31'd0, evt_valid}, 32'h0);

    // 5: same stimulus with a ready consumer -> ch0 then ch3, no overflow
    do_reset();
    evt_ready = 1'b1;
    run_to(8);
    sw_in = 4'b1001;
    run_to(49);
    check("t5_valid0", {31'd0, evt_valid}, 32'h1);
    check("t5_ch0",    {30'd0, evt_ch}, 32'h0);
    step();
    check("t5_gap", {31'd0, evt_valid}, 32'h0);
    run_to(52);
    check("t5_valid3", {31'd0, evt_valid}, 32'h1);
    check("t5_ch3",    {30'd0, evt_ch}, 32'h3);
    check("t5_press3", {31'd0, evt_press}, 32'h1);
    check("t5_ovf",    {31'd0, overflow}, 32'h0);
    step();
    check("t5_drained", {31'd0, evt_valid}, 32'h0);

    // 6: async reset mid-scan with an event pending
    do_reset();
    run_to(8);
    sw_in = 4'b0001;
    run_to(49);
    check("t6_pre_valid", {31'd0, evt_valid}, 32'h1);
    reset = 1'b0;
    #1;
    check("t6_level", {28'd0, sw_level}, 32'h0);
    check("t6_valid", {31'd0, evt_valid}, 32'h0);
    check("t6_ch",    {30'd0, evt_ch}, 32'h0);
    check("t6_press", {31'd0, evt_press}, 32'h0);
    check("t6_ovf",   {31'd0, overflow}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
    run_to(48);
    check("t6_rel_pre_level", {28'd0, sw_level}, 32'h0);
    step();
    check("t6_rel_level", {28'd0, sw_level}, 32'h1);
    check("t6_rel_valid", {31'd0, evt_valid}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
